// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: opcode constants and opcode-name helper for the logic unit
package logic_unit_pkg;
   localparam logic [2:0] OP_AND   = 3'b000;
   localparam logic [2:0] OP_OR    = 3'b001;
   localparam logic [2:0] OP_NAND  = 3'b010;
   localparam logic [2:0] OP_NOR   = 3'b011;
   localparam logic [2:0] OP_XOR   = 3'b100;
   localparam logic [2:0] OP_XNOR  = 3'b101;
   localparam logic [2:0] OP_NOTA  = 3'b110;
   localparam logic [2:0] OP_PASSB = 3'b111;

   function automatic string op_name(input logic [2:0] op);
      return op == OP_AND  ? "AND"  : op == OP_OR   ? "OR"   :
             op == OP_NAND ? "NAND" : op == OP_NOR  ? "NOR"  :
             op == OP_XOR  ? "XOR"  : op == OP_XNOR ? "XNOR" :
             op == OP_NOTA ? "NOTA" : "PASSB";
   endfunction
endpackage

// File: rtl/logic_unit_core.sv
// logic_unit_core: combinational bitwise function selected by opcode
module logic_unit_core
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] f
);
   // select the bitwise operation; NOT A ignores b, PASS B ignores a
   always_comb begin
      case (op)
         OP_AND:  f = a & b;
         OP_OR:   f = a | b;
         OP_NAND: f = ~(a & b);
         OP_NOR:  f = ~(a | b);
         OP_XOR:  f = a ^ b;
         OP_XNOR: f = ~(a ^ b);
         OP_NOTA: f = ~a;
         default: f = b;
      endcase
   end
endmodule

// File: rtl/logic_unit_acc.sv
// logic_unit_acc: registered logic unit with accumulator, handshake, flags and counter
module logic_unit_acc
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic             acc_mode,
   input  logic             clr,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             parity,
   output logic [WIDTH-1:0] acc,
   output logic [CNT_W-1:0] op_count
);
   logic             valid_q, valid_d, zero_q, zero_d, parity_q, parity_d, accept;
   logic [WIDTH-1:0] res_q, res_d, acc_q, acc_d, a_eff, f;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign a_eff    = acc_mode ? (clr ? '0 : acc_q) : a;

   logic_unit_core #(.WIDTH(WIDTH)) u_core (.op(op), .a(a_eff), .b(b), .f(f));

   // next state: an accept loads result, flags and accumulator; otherwise clr may zero the accumulator
   always_comb begin
      res_d    = accept ? f : res_q;
      zero_d   = accept ? ~|f : zero_q;
      parity_d = accept ? ^f : parity_q;
      acc_d    = accept ? f : (clr ? '0 : acc_q);
      cnt_d    = accept ? cnt_q + CNT_W'(1) : cnt_q;
      valid_d  = accept ? 1'b1 : (out_ready ? 1'b0 : valid_q);
   end

   // state registers; reset drops any pending result
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q  <= 1'b0;
         res_q    <= '0;
         zero_q   <= 1'b1;
         parity_q <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         res_q    <= res_d;
         zero_q   <= zero_d;
         parity_q <= parity_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   assign out_valid = valid_q;
   assign result    = res_q;
   assign zero      = zero_q;
   assign parity    = parity_q;
   assign acc       = acc_q;
   assign op_count  = cnt_q;
endmodule

// File: tb/tb_logic_unit_acc.sv
// tb_logic_unit_acc: randomized and directed checks against a transaction-level model
module tb_logic_unit_acc;
   import logic_unit_pkg::*;

   logic       clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_ready, acc_mode = 1'b0, clr = 1'b0;
   logic       out_valid, out_ready = 1'b1, zero, parity;
   logic [2:0] op = 3'd0;
   logic [7:0] a = 8'd0, b = 8'd0, result, acc, op_count;
   int         total = 0, bad = 0;

   logic       m_valid = 1'b0, started = 1'b0;
   logic [7:0] m_res = 8'd0, m_acc = 8'd0, m_cnt = 8'd0;

   logic_unit_acc #(.WIDTH(8), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .acc_mode(acc_mode), .clr(clr), .a(a), .b(b), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .zero(zero), .parity(parity),
      .acc(acc), .op_count(op_count)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] fn(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
      case (o)
         3'd0: return x & y;
         3'd1: return x | y;
         3'd2: return ~(x & y);
         3'd3: return ~(x | y);
         3'd4: return x ^ y;
         3'd5: return ~(x ^ y);
         3'd6: return ~x;
         default: return y;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // transaction-level model updated from the inputs seen at each rising edge
   always @(posedge clk) begin
      logic fire;
      logic [7:0] x, f;
      fire = in_valid && (!m_valid || out_ready);
      if (reset) begin
         m_valid = 1'b0; m_res = 8'd0; m_acc = 8'd0; m_cnt = 8'd0;
      end else if (fire) begin
         x = acc_mode ? (clr ? 8'd0 : m_acc) : a;
         f = fn(op, x, b);
         m_res = f; m_acc = f; m_cnt = m_cnt + 8'd1; m_valid = 1'b1;
      end else begin
         if (clr) m_acc = 8'd0;
         if (out_ready) m_valid = 1'b0;
      end
      started = 1'b1;
   end

   // every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (started) begin
         chk("out_valid", out_valid, m_valid);
         chk("result", result, m_res);
         chk("zero", zero, m_res == 8'd0);
         chk("parity", parity, ^m_res);
         chk("acc", acc, m_acc);
         chk("op_count", op_count, m_cnt);
         chk("in_ready", in_ready, !m_valid || out_ready);
      end
   end

   logic [7:0] exp8 [8];
   logic [7:0] chain [4];
   logic [7:0] c;

   initial begin
      exp8  = '{8'h81, 8'hE7, 8'h7E, 8'h18, 8'h66, 8'h99, 8'h3C, 8'hA5};
      chain = '{8'h01, 8'h03, 8'h07, 8'h87};
      step(); step();
      chk("reset_zero", zero, 1'b1);
      chk("reset_valid", out_valid, 1'b0);
      reset = 1'b0;
      #1;
      chk("ready_after_reset", in_ready, 1'b1);

      in_valid = 1'b1; a = 8'hC3; b = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         op = 3'(i);
         step();
         total++;
         if (result !== exp8[i] || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL op_%s: got %0h expected %0h", op_name(op), result, exp8[i]);
         end
         chk("op_zero", zero, 1'b0);
         chk("op_parity", parity, ^exp8[i]);
      end
      in_valid = 1'b0;
      step();
      chk("count8", op_count, 8'd8);

      clr = 1'b1;
      step();
      clr = 1'b0; acc_mode = 1'b1; op = OP_OR; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         b = 8'(1 << (i == 3 ? 7 : i));
         step();
         chk("chain_acc", acc, chain[i]);
         chk("chain_res", result, chain[i]);
      end
      op = OP_XOR; b = 8'h87;
      step();
      chk("xor_res", result, 8'h00);
      chk("xor_zero", zero, 1'b1);
      chk("xor_parity", parity, 1'b0);

      acc_mode = 1'b0; op = OP_AND; a = 8'h0F; b = 8'hFF;
      step();
      out_ready = 1'b0; op = OP_OR; a = 8'h55;
      c = op_count;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_ready", in_ready, 1'b0);
         chk("stall_res", result, 8'h0F);
         step();
      end
      chk("stall_count", op_count, c);
      out_ready = 1'b1;
      #1;
      chk("release_ready", in_ready, 1'b1);
      step();
      chk("release_res", result, 8'hFF);
      chk("release_count", op_count, c + 8'd1);

      op = OP_PASSB;
      for (int i = 0; i < 10; i++) begin
         b = 8'(i + 1);
         step();
         chk("b2b_valid", out_valid, 1'b1);
         chk("b2b_res", result, 8'(i + 1));
      end

      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 258; i++) step();
      in_valid = 1'b0;
      step();
      chk("wrap_count", op_count, 8'd2);

      in_valid = 1'b1; op = OP_PASSB; b = 8'hFF;
      step();
      chk("acc_ff", acc, 8'hFF);
      acc_mode = 1'b1; clr = 1'b1; op = OP_OR; b = 8'h10;
      step();
      chk("clr_acc_res", result, 8'h10);
      chk("clr_acc_acc", acc, 8'h10);
      clr = 1'b0; acc_mode = 1'b0;

      out_ready = 1'b0; a = 8'h3C; op = OP_NOTA;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0; in_valid = 1'b0;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_res", result, 8'h00);
      chk("rst_acc", acc, 8'h00);
      chk("rst_count", op_count, 8'h00);
      chk("rst_zero", zero, 1'b1);
      chk("rst_ready", in_ready, 1'b1);

      for (int i = 0; i < 3000; i++) begin
         reset     = ($urandom_range(0, 199) == 0);
         in_valid  = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 2) != 0;
         acc_mode  = $urandom_range(0, 1) != 0;
         clr       = $urandom_range(0, 7) == 0;
         op        = 3'($urandom_range(0, 7));
         a         = 8'($urandom);
         b         = 8'($urandom);
         step();
      end
      reset = 1'b0; in_valid = 1'b0;
      step(); step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/logic_unit_acc.md
Name: logic_unit_acc

Overview:
- WIDTH-bit registered logic unit with six bitwise operations plus NOT A and PASS B, selected by a 3-bit opcode.
- Optional accumulator mode feeds the previous result back as operand A, so chained reductions can be built.
- Valid/ready handshake on both sides, one pipeline stage, status flags and a transaction counter.
- Sits between the register-file/operand path and the result bus of the datapath exercises, as the sequential successor of the single-bit selectable gate cell.

Parameters:
- WIDTH, 8, operand/result width in bits (≥1)
- CNT_W, 8, width of transaction counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands/opcode valid
- in_ready  output  1  unit can accept a transaction this cycle
- op  input  3  opcode: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110 NOT A, 111 PASS B
- acc_mode  input  1  1: operand A = accumulator; 0: operand A = a
- clr  input  1  clear accumulator
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  result register holds an unconsumed result
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  registered result
- zero  output  1  result == 0 (registered with result)
- parity  output  1  XOR-reduction of result (registered with result)
- acc  output  WIDTH  current accumulator value
- op_count  output  CNT_W  accepted-transaction count

Behaviour:
- Reset (synchronous, active-high, at the clk edge): out_valid=0, result=0, zero=1, parity=0, acc=0, op_count=0. in_ready=1 in the cycle after reset deasserts. Reset overrides every other input, including a mid-transaction or a held result; the pending result is dropped.
- in_ready = !out_valid || out_ready (combinational; single-stage pipeline, full throughput).
- Accept when in_valid && in_ready. Latency 1: result visible with out_valid=1 on the cycle after the accept edge.
- Effective A: acc_mode ? (clr ? 0 : acc) : a. The result is computed bitwise over WIDTH bits. Ops 110/111 ignore B/A respectively.
- On accept: result←f(A,b), zero←(f==0), parity←^f, acc←f, op_count←op_count+1 (wraps at 2^CNT_W, no saturation).
- No accept: acc←clr ? 0 : acc. Result, zero and parity hold.
- out_valid next: accept ? 1 : (out_ready ? 0 : out_valid).
- Simultaneous consume and accept in the same cycle: the new result replaces the old one, out_valid stays 1, no bubble.
- Backpressure: while out_valid=1 && out_ready=0, in_ready=0. result/zero/parity stay stable. Inputs are ignored even if in_valid=1.
- clr together with an accepted acc_mode=0 transaction: acc loads the new result (accept wins).
- op, a, b, acc_mode are sampled only on accept. Changes while not accepted have no effect.
- No X propagation: all outputs are defined from reset onward.

Decomposition:
- Shared package logic_unit_pkg: opcode constants (OP_AND..OP_PASSB, 3-bit localparams) and the opcode-name function used by the bench for printing.
- One combinational sub-module logic_unit_core (WIDTH-parameterised; ports: op, a, b → f). The top holds the handshake, the result/flag registers, the accumulator and the counter.

Test Plan:
- Reset, then all 8 ops with a=8'hC3, b=8'hA5, acc_mode=0, out_ready=1. Required results, one per cycle at latency 1: 81, E7, 7E, 18, 66, 99, 3C, A5. op_count reaches 8. zero=0 throughout; parity matches each result.
- Accumulator chain: clr pulse, then OR with acc_mode=1 and b=01, 02, 04, 80 → acc/result 01, 03, 07, 87. Then XOR b=87 → result 00, zero=1, parity=0.
- Backpressure: out_ready=0 for 3 cycles after accept of AND 0F&FF. Required: result=0F held, in_ready=0, op_count unchanged by in_valid during the stall. Release out_ready → the next transaction is accepted in that same cycle.
- Back-to-back throughput: in_valid=1, out_ready=1 for 10 cycles. Required: 10 results on 10 consecutive cycles. op_count after 256+2 accepts (CNT_W=8) reads 2 (wrap).
- Simultaneous clr and accepted acc_mode=1 OR with b=0x10 while acc=0xFF → result 0x10 (A treated as 0), acc=0x10.
- Reset asserted while out_valid=1 && out_ready=0 → next cycle out_valid=0, result=0, acc=0, op_count=0, zero=1; in_ready=1 after deassert.
